fetch_queue: RTL

- Decoupling FIFO between instruction fetch and decode.
- Buffers fetched instruction packets (pc, ir, predicted next pc, prediction bit, order), so fetch keeps running while decode stalls.
- Flushed in one cycle on any branch/jump misprediction resolved in execute.
- Registered-output FIFO with valid/ready handshakes on both sides; no enqueue-to-dequeue bypass.

---
 rtl/fetch_queue.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode: circular buffer of instruction packets,
// registered state, single-cycle flush on misprediction, no enqueue-to-dequeue bypass.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [XLEN-1:0]            enq_ir,
  input  logic [XLEN-1:0]            enq_br_pc,
  input  logic                       enq_br_taken,
  input  logic [63:0]                enq_order,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_ir,
  output logic [XLEN-1:0]            deq_br_pc,
  output logic                       deq_br_taken,
  output logic [63:0]                deq_order,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_ir    [DEPTH];
  logic [XLEN-1:0] mem_br_pc [DEPTH];
  logic            mem_taken [DEPTH];
  logic [63:0]     mem_order [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count_q;
  logic          enq_fire;
  logic          deq_fire;

  assign enq_ready = (count_q < CW'(DEPTH));
  assign deq_valid = (count_q != '0) & ~flush;
  assign enq_fire  = enq_valid & enq_ready & ~flush;
  assign deq_fire  = deq_valid & deq_ready;
  assign count     = count_q;

  assign deq_pc       = mem_pc[head];
  assign deq_ir       = mem_ir[head];
  assign deq_br_pc    = mem_br_pc[head];
  assign deq_br_taken = mem_taken[head];
  assign deq_order    = mem_order[head];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) tail <= tail + AW'(1);
      if (deq_fire) head <= head + AW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload is never reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (rst && enq_fire) begin
      mem_pc[tail]    <= enq_pc;
      mem_ir[tail]    <= enq_ir;
      mem_br_pc[tail] <= enq_br_pc;
      mem_taken[tail] <= enq_br_taken;
      mem_order[tail] <= enq_order;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      assert (count_q <= CW'(DEPTH)) else $error("fetch_queue: count overflow");
      assert (!(enq_fire && count_q == CW'(DEPTH))) else $error("fetch_queue: enqueue while full");
      assert (!(deq_fire && count_q == '0)) else $error("fetch_queue: dequeue while empty");
    end
  end
`endif

endmodule
